fifo_sync_param: RTL and testbench

- Single-clock, parametrised-width, parametrised-depth FIFO; successor to the dual-strobe FIFO.
- Replaces strobe-ORed pseudo-clocking with one clock plus write/read enables.
- Adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Sits between a data producer and a consumer in the same clock domain.

---
 rtl/fifo_sync_param_if.sv | 35 +++
 rtl/fifo_sync_param.sv | 137 +++++++++++++
 tb/tb_fifo_sync_param.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// Handshake/data bundle between a producer, the fifo_sync_param FIFO and a consumer.
// master: the side that drives writes/reads; slave: the FIFO itself.
interface fifo_sync_param_if #(
    parameter int DATO_WIDTH  = 8,
    parameter int FIFO_LENGTH = 5
);
    localparam int CW = $clog2(FIFO_LENGTH + 1);

    logic [DATO_WIDTH-1:0] datin;
    logic                  wr;
    logic                  rd;
    logic                  clr_err;
    logic [DATO_WIDTH-1:0] datout;
    logic                  dout_valid;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empy;
    logic                  dato;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output datin, wr, rd, clr_err,
        input  datout, dout_valid, count, full, empy, dato,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  datin, wr, rd, clr_err,
        output datout, dout_valid, count, full, empy, dato,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with arbitrary depth, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional build macro FIFO_BYPASS_EN: a simultaneous write+read on an empty
// FIFO forwards datin straight to datout instead of storing it.
module fifo_sync_param #(
    parameter int DATO_WIDTH  = 8,
    parameter int FIFO_LENGTH = 5,
    parameter int AF_LEVEL    = FIFO_LENGTH - 1,
    parameter int AE_LEVEL    = 1
) (
    input  logic                clk,
    input  logic                rst,
    fifo_sync_param_if.slave    bus
);
    localparam int PW = $clog2(FIFO_LENGTH);
    localparam int CW = $clog2(FIFO_LENGTH + 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_LENGTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_LENGTH);
    localparam logic [CW-1:0] CNT_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE    = CW'(AE_LEVEL);

    // Explicit wrap keeps the pointer valid for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    logic [DATO_WIDTH-1:0] mem_r [FIFO_LENGTH];
    logic [PW-1:0]         wptr_r;
    logic [PW-1:0]         rptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nxt_s;
    logic [DATO_WIDTH-1:0] datout_r;
    logic                  dout_valid_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic empty_s;
    logic full_s;
    logic byp_s;
    logic rd_acc_s;
    logic wr_store_s;
    logic ovf_set_s;
    logic unf_set_s;

    assign empty_s = (count_r == {CW{1'b0}});
    assign full_s  = (count_r == CNT_FULL);

`ifdef FIFO_BYPASS_EN
    assign byp_s = bus.wr && bus.rd && empty_s;
`else
    assign byp_s = 1'b0;
`endif

    // Request acceptance and error-event detection for this cycle.
    always_comb begin
        rd_acc_s   = 1'b0;
        wr_store_s = 1'b0;
        ovf_set_s  = 1'b0;
        unf_set_s  = 1'b0;
        rd_acc_s   = bus.rd && !empty_s;
        // A read at full frees a slot, so the write can land in it.
        wr_store_s = bus.wr && (!full_s || rd_acc_s) && !byp_s;
        ovf_set_s  = bus.wr && full_s && !bus.rd;
        unf_set_s  = bus.rd && empty_s && !byp_s;
    end

    // Next occupancy: simultaneous store and read cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_store_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; contents need no reset, writes are suppressed during reset.
    always_ff @(posedge clk) begin
        if (rst && wr_store_s) begin
            mem_r[wptr_r] <= bus.datin;
        end
    end

    // Pointers, count, read data and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_r       <= {PW{1'b0}};
            rptr_r       <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            datout_r     <= {DATO_WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (wr_store_s) begin
                wptr_r <= ptr_inc(wptr_r);
            end
            if (rd_acc_s) begin
                rptr_r       <= ptr_inc(rptr_r);
                datout_r     <= mem_r[rptr_r];
                dout_valid_r <= 1'b1;
            end else if (byp_s) begin
                datout_r     <= bus.datin;
                dout_valid_r <= 1'b1;
            end else begin
                dout_valid_r <= 1'b0;
            end
            // A new error event in the same cycle as clr_err keeps the flag set.
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_r <= 1'b0;
            end
            if (unf_set_s) begin
                underflow_r <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    assign bus.datout       = datout_r;
    assign bus.dout_valid   = dout_valid_r;
    assign bus.count        = count_r;
    assign bus.full         = full_s;
    assign bus.empy         = empty_s;
    assign bus.dato         = !empty_s && !full_s;
    assign bus.almost_full  = (count_r >= CNT_AF);
    assign bus.almost_empty = (count_r <= CNT_AE);
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (DATO_WIDTH=8, FIFO_LENGTH=5):
// directed vector table, wrap-around sequence and randomized traffic against
// a queue-based reference model.
module tb_fifo_sync_param;
    localparam int DW = 8;
    localparam int FL = 5;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    fifo_sync_param_if #(.DATO_WIDTH(DW), .FIFO_LENGTH(FL)) bus ();

    fifo_sync_param #(.DATO_WIDTH(DW), .FIFO_LENGTH(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rd;
        logic        clr;
        logic [7:0]  din;
        logic [2:0]  c;
        logic [7:0]  d;
        logic        v;
        logic        o;
        logic        u;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_v;
    logic       m_o;
    logic       m_u;

    task automatic add(input logic r, input logic w, input logic rr, input logic cl,
                       input logic [7:0] di, input logic [2:0] c, input logic [7:0] d,
                       input logic v, input logic o, input logic u);
        vec_t e;
        e.rst = r; e.wr = w; e.rd = rr; e.clr = cl; e.din = di;
        e.c = c; e.d = d; e.v = v; e.o = o; e.u = u;
        tbl.push_back(e);
    endtask

    task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    // Full output check; status flags are derived from the expected occupancy.
    task automatic check_all(input string nm, input int idx, input logic [2:0] c,
                             input logic [7:0] d, input logic v, input logic o, input logic u);
        int n;
        n = int'(c);
        cmp({nm, "_count"}, idx, 32'(bus.count), 32'(c));
        cmp({nm, "_datout"}, idx, 32'(bus.datout), 32'(d));
        cmp({nm, "_valid"}, idx, 32'(bus.dout_valid), 32'(v));
        cmp({nm, "_full"}, idx, 32'(bus.full), 32'(n == FL));
        cmp({nm, "_empy"}, idx, 32'(bus.empy), 32'(n == 0));
        cmp({nm, "_dato"}, idx, 32'(bus.dato), 32'(n > 0 && n < FL));
        cmp({nm, "_afull"}, idx, 32'(bus.almost_full), 32'(n >= FL - 1));
        cmp({nm, "_aempty"}, idx, 32'(bus.almost_empty), 32'(n <= 1));
        cmp({nm, "_ovf"}, idx, 32'(bus.overflow), 32'(o));
        cmp({nm, "_unf"}, idx, 32'(bus.underflow), 32'(u));
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic w, input logic rr, input logic cl, input logic [7:0] di);
        rst         = r;
        bus.wr      = w;
        bus.rd      = rr;
        bus.clr_err = cl;
        bus.datin   = di;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: FIFO as a queue, rules taken directly from the behaviour description.
    task automatic model_step(input logic r, input logic w, input logic rr, input logic cl, input logic [7:0] di);
        int n;
        bit rd_ok;
        bit wr_ok;
        bit byp;
        n   = q.size();
        byp = 1'b0;
        if (!r) begin
            q.delete();
            m_dout = 8'h00;
            m_v    = 1'b0;
            m_o    = 1'b0;
            m_u    = 1'b0;
        end else begin
            rd_ok = rr && (n > 0);
`ifdef FIFO_BYPASS_EN
            byp = w && rr && (n == 0);
`endif
            wr_ok = w && ((n < FL) || rd_ok) && !byp;
            m_v = 1'b0;
            if (rd_ok) begin
                m_dout = q.pop_front();
                m_v    = 1'b1;
            end else if (byp) begin
                m_dout = di;
                m_v    = 1'b1;
            end
            if (wr_ok) q.push_back(di);
            if (w && n == FL && !rr) m_o = 1'b1;
            else if (cl) m_o = 1'b0;
            if (rr && n == 0 && !byp) m_u = 1'b1;
            else if (cl) m_u = 1'b0;
        end
    endtask

    task automatic run_cycle(input string nm, input int idx, input logic r, input logic w,
                             input logic rr, input logic cl, input logic [7:0] di);
        model_step(r, w, rr, cl, di);
        step(r, w, rr, cl, di);
        check_all(nm, idx, 3'(q.size()), m_dout, m_v, m_o, m_u);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0; bus.datin = 8'h00;

        //   rst   wr    rd    clr   din     cnt   dout   v     o     u
        add(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h66, 3'd5, 8'h00, 1'b0, 1'b1, 1'b0); // dropped write
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 8'h11, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 3'd5, 8'h11, 1'b0, 1'b0, 1'b0); // clr + refill
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 8'h22, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 8'h33, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 8'h44, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 8'h55, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h66, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h66, 1'b0, 1'b0, 1'b1); // underflow
        add(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 8'h66, 1'b0, 1'b0, 1'b1); // set beats clear
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h66, 1'b0, 1'b0, 1'b0);
`ifdef FIFO_BYPASS_EN
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 3'd0, 8'h3C, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h3C, 1'b0, 1'b0, 1'b0);
`else
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 3'd1, 8'h66, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 8'h66, 1'b0, 1'b0, 1'b0);
`endif
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd5, 8'h01, 1'b1, 1'b0, 1'b0); // wr+rd at full
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 8'h02, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 8'h03, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 8'h05, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'hA5, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h71, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h72, 3'd2, 8'hA5, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h73, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 8'h74, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0); // reset mid-op
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1); // nothing stored
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
            check_all("tbl", i, tbl[i].c, tbl[i].d, tbl[i].v, tbl[i].o, tbl[i].u);
        end

        // Wrap-around: 12 writes kept at most 3 deep, pointers wrap 4->0 twice.
        run_cycle("wrap", 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 12; k++) begin
            run_cycle("wrap", k + 1, 1'b1, 1'b1, (k >= 3) ? 1'b1 : 1'b0, 1'b0, 8'(8'hC0 + k));
            cmp("wrap_depth", k, 32'(bus.count <= 3'd3), 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            run_cycle("wrap_drain", k, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        end

        // Randomized traffic against the queue model.
        run_cycle("rand", 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k < 400; k++) begin
            logic r, w, rr, cl;
            r  = ($urandom_range(0, 59) != 0);
            w  = ($urandom_range(0, 99) < 55);
            rr = ($urandom_range(0, 99) < 45);
            cl = ($urandom_range(0, 19) == 0);
            run_cycle("rand", k, r, w, rr, cl, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
